tx_seq_arbiter: RTL and testbench
=================================

Name: tx_seq_arbiter

Overview:
- Transmit-side TLP source arbiter for the PCIe Gen5 transaction layer.
- Four requesters: A2P_1 (read, non-posted), A2P_2 (write, posted), Master (completion), Rx Router (completion or message).
- An internal sequence recorder FIFO logs the cycle-by-cycle arrival order of requests.
- Grants are issued strictly in arrival order, with a fixed priority only among requests that arrived in the same cycle.

Parameters:
- DATA_WIDTH, 5, recorder entry width; one bit per request source.
- FIFO_DEPTH, 8, number of recorder entries; must be a power of two and at least 5.

Ports:
- clk  in  1  single clock; rising edge.
- arst  in  1  reset, synchronous, active-high (name kept as used in the codebase).
- a2p1_valid  in  1  A2P_1 read request.
- a2p1_grant  out  1  grant to A2P_1.
- a2p2_valid  in  1  A2P_2 write request.
- a2p2_grant  out  1  grant to A2P_2.
- master_valid  in  1  Master completion request.
- master_grant  out  1  grant to Master.
- rx_router_valid  in  2  Rx Router requests; bit0 = completion, bit1 = message; the two bits are independent.
- rx_router_grant  out  2  per-bit grant to Rx Router.
- tx_ready  in  1  downstream TLP path can accept one TLP this cycle.
- fifo_empty  out  1  recorder holds no entries.
- fifo_full  out  1  recorder holds FIFO_DEPTH entries.

Behaviour:
- Source index and priority order: 0 = A2P_1, 1 = A2P_2, 2 = Master, 3 = Rx completion, 4 = Rx message.
- req[4:0] is the concatenation of the valid bits in that index order.
- pending[4:0] register: bit set when a request is recorded; cleared only when that source is granted.
- new_req = req & ~pending.
- Record: at a clock edge where new_req != 0 and the FIFO is not full, push new_req as one entry.
  - If the FIFO is full, nothing is pushed and pending is unchanged. The source is resampled next cycle while it holds valid.
- A recorded request is committed. Dropping valid afterwards does not cancel it.
- Head masking: served[4:0] register marks bits of the head entry already granted. remaining = head & ~served.
- Grant (combinational, one-hot or zero): when tx_ready=1 and fifo_empty=0, assert the grant of the lowest-index set bit of remaining. Otherwise all grants are 0.
- Exactly one grant per cycle at most. A grant means one TLP is accepted that cycle.
- On a clock edge with a grant:
  - the granted pending bit clears;
  - served gets that bit set;
  - if it was the last remaining bit, the head is popped and served clears to 0.
- Push and pop may occur on the same edge. Full/empty flags are computed from the count after both.
- A source still asserting valid after its grant edge is seen as a new request. It is recorded at the next edge, earliest, and queued behind existing entries.
- Latency: a request into an idle arbiter with tx_ready=1 is recorded at the end of cycle N and granted in cycle N+1.
- tx_ready=0: no grants, no pops; recording continues.
- Pointers wrap modulo FIFO_DEPTH. An extra wrap bit distinguishes full from empty.
- Reset (arst=1 at a clock edge) applies at any time, including mid-sequence:
  - pointers, count, pending and served clear;
  - fifo_empty=1, fifo_full=0, all grants 0;
  - valid is ignored during the reset cycle.

Decomposition:
- Package tx_arbiter_pkg holds:
  - DATA_WIDTH=5, FIFO_DEPTH=8;
  - source index localparams or enum (SRC_A2P1..SRC_RX_MSG);
  - a typedef for the entry bitmask.
- Sub-module seq_recorder_fifo: synchronous FIFO (push/pop/head/full/empty).
- The top holds pending/served logic and the grant encoder.

Test Plan:
- arst=1 for 2 cycles with random valids -> all grants 0, fifo_empty=1, fifo_full=0 throughout; after release, the first grant appears no earlier than the second cycle after a valid.
- a2p2_valid=1 for cycle 0 only, tx_ready=1 -> a2p2_grant=1 in cycle 1 only; fifo_empty=1 from cycle 2.
- master_valid in cycle 0, a2p1_valid in cycle 1, both held, tx_ready=1 -> master_grant in cycle 1, a2p1_grant in cycle 2; arrival order overrides priority.
- a2p1, a2p2 and rx_router_valid=2'b11 all in cycle 0, then dropped -> grants a2p1 c1, a2p2 c2, rx_router_grant=01 c3, rx_router_grant=10 c4; then empty.
- tx_ready=0 for 5 cycles while master and a2p1 are held from cycles 0 and 1 -> no grants; exactly 2 entries (no duplicates); tx_ready=1 at cycle 5 -> master c5, a2p1 c6.
- Three requests recorded, arst=1 at cycle 2 -> no grants after the reset edge; fifo_empty=1; held valids re-recorded after release.

Source files
------------

// File: rtl/tx_seq_arbiter_pkg.sv
// Shared constants, source indices and mask type for the TX TLP source arbiter.
// Source index order is also the tie-break priority order (lowest index wins).
package tx_arbiter_pkg;

    localparam int DATA_WIDTH = 5;
    localparam int FIFO_DEPTH = 8;

    localparam int SRC_A2P1   = 0;
    localparam int SRC_A2P2   = 1;
    localparam int SRC_MASTER = 2;
    localparam int SRC_RX_CPL = 3;
    localparam int SRC_RX_MSG = 4;

    typedef logic [DATA_WIDTH-1:0] src_mask_t;

    // One-hot of the lowest set bit; zero in, zero out.
    function automatic src_mask_t lowest_set(input src_mask_t m);
        return m & (~m + src_mask_t'(1));
    endfunction

endpackage

// File: rtl/tx_seq_arbiter_if.sv
// Requester/arbiter handshake bundle for the TX TLP source arbiter.
// The master side is the requester/downstream environment, the slave side is the arbiter.
interface tx_seq_arbiter_if;

    logic       a2p1_valid;
    logic       a2p1_grant;
    logic       a2p2_valid;
    logic       a2p2_grant;
    logic       master_valid;
    logic       master_grant;
    logic [1:0] rx_router_valid;
    logic [1:0] rx_router_grant;
    logic       tx_ready;
    logic       fifo_empty;
    logic       fifo_full;

    modport master (
        output a2p1_valid,
        output a2p2_valid,
        output master_valid,
        output rx_router_valid,
        output tx_ready,
        input  a2p1_grant,
        input  a2p2_grant,
        input  master_grant,
        input  rx_router_grant,
        input  fifo_empty,
        input  fifo_full
    );

    modport slave (
        input  a2p1_valid,
        input  a2p2_valid,
        input  master_valid,
        input  rx_router_valid,
        input  tx_ready,
        output a2p1_grant,
        output a2p2_grant,
        output master_grant,
        output rx_router_grant,
        output fifo_empty,
        output fifo_full
    );

endinterface

// File: rtl/tx_seq_arbiter_seq_recorder_fifo.sv
// Arrival-order recorder: synchronous FIFO of per-cycle request masks.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module seq_recorder_fifo #(
    parameter int DATA_WIDTH = 5,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // A full FIFO refuses the push even when a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !arst) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/tx_seq_arbiter.sv
// TX TLP source arbiter: grants strictly in arrival order, fixed priority only
// among requests that arrived on the same cycle.
module tx_seq_arbiter
    import tx_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             arst,
    tx_seq_arbiter_if.slave  bus
);

    src_mask_t req;
    src_mask_t new_req;
    src_mask_t pending;
    src_mask_t served;
    src_mask_t head;
    src_mask_t remaining;
    src_mask_t grant_vec;
    logic      fifo_push;
    logic      fifo_pop;
    logic      fifo_full;
    logic      fifo_empty;

    always_comb begin
        req             = '0;
        req[SRC_A2P1]   = bus.a2p1_valid;
        req[SRC_A2P2]   = bus.a2p2_valid;
        req[SRC_MASTER] = bus.master_valid;
        req[SRC_RX_CPL] = bus.rx_router_valid[0];
        req[SRC_RX_MSG] = bus.rx_router_valid[1];
    end

    // A source already recorded and not yet granted is not re-recorded.
    assign new_req   = req & ~pending;
    assign fifo_push = |new_req;
    assign remaining = head & ~served;

    always_comb begin
        grant_vec = '0;
        if (!arst && bus.tx_ready && !fifo_empty) begin
            grant_vec = lowest_set(remaining);
        end
    end

    assign fifo_pop = (|grant_vec) && ((remaining & ~grant_vec) == '0);

    always_ff @(posedge clk) begin
        if (arst) begin
            pending <= '0;
            served  <= '0;
        end else begin
            pending <= (pending | (fifo_full ? '0 : new_req)) & ~grant_vec;
            if (fifo_pop) begin
                served <= '0;
            end else begin
                served <= served | grant_vec;
            end
        end
    end

    seq_recorder_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_recorder (
        .clk       (clk),
        .arst      (arst),
        .push      (fifo_push),
        .push_data (new_req),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.a2p1_grant      = grant_vec[SRC_A2P1];
    assign bus.a2p2_grant      = grant_vec[SRC_A2P2];
    assign bus.master_grant    = grant_vec[SRC_MASTER];
    assign bus.rx_router_grant = {grant_vec[SRC_RX_MSG], grant_vec[SRC_RX_CPL]};
    assign bus.fifo_empty      = fifo_empty;
    assign bus.fifo_full       = fifo_full;

endmodule

// File: tb/tb_tx_seq_arbiter.sv
// Bench for tx_seq_arbiter: directed arrival-order scenarios plus random traffic,
// checked against a queue-of-arrival-groups reference model.
module tb_tx_seq_arbiter;
    import tx_arbiter_pkg::*;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    tx_seq_arbiter_if bus();

    tx_seq_arbiter dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: each queue element is the set of sources that arrived together
    // and are still waiting; the front group is served lowest index first.
    logic [4:0] mq[$];
    logic [4:0] m_pend;
    logic [4:0] obs_grant;
    logic       obs_empty;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] model_grant(input logic rst, input logic rdy);
        logic [4:0] g;
        logic       found;
        g = '0;
        found = 1'b0;
        if (!rst && rdy && mq.size() > 0) begin
            for (int i = 0; i < 5; i++) begin
                if (!found && mq[0][i]) begin
                    g[i]  = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return g;
    endfunction

    // One clock cycle: drive at negedge, check mid-cycle, advance model at posedge.
    task automatic step(input logic rst, input logic [4:0] req, input logic rdy);
        logic [4:0] eg;
        logic [4:0] nw;
        int         sz;
        arst                = rst;
        bus.a2p1_valid      = req[0];
        bus.a2p2_valid      = req[1];
        bus.master_valid    = req[2];
        bus.rx_router_valid = req[4:3];
        bus.tx_ready        = rdy;
        #1;
        eg        = model_grant(rst, rdy);
        obs_grant = {bus.rx_router_grant, bus.master_grant, bus.a2p2_grant, bus.a2p1_grant};
        obs_empty = bus.fifo_empty;
        chk("grant", {3'b0, obs_grant}, {3'b0, eg});
        chk("fifo_empty", {7'b0, bus.fifo_empty}, {7'b0, mq.size() == 0});
        chk("fifo_full", {7'b0, bus.fifo_full}, {7'b0, mq.size() == FIFO_DEPTH});
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_pend = '0;
        end else begin
            sz = mq.size();
            nw = req & ~m_pend;
            if (eg != '0) begin
                mq[0]  = mq[0] & ~eg;
                m_pend = m_pend & ~eg;
                if (mq[0] == '0) void'(mq.pop_front());
            end
            if (nw != '0 && sz < FIFO_DEPTH) begin
                mq.push_back(nw);
                m_pend = m_pend | nw;
            end
        end
        @(negedge clk);
    endtask

    logic [4:0] rq;
    logic       rr;
    logic       rs;
    int         ready_pct;

    initial begin
        arst                = 1'b1;
        bus.a2p1_valid      = 1'b0;
        bus.a2p2_valid      = 1'b0;
        bus.master_valid    = 1'b0;
        bus.rx_router_valid = 2'b00;
        bus.tx_ready        = 1'b0;
        mq.delete();
        m_pend = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset held with random valids: nothing granted, flags at reset values.
        repeat (2) step(1'b1, 5'($urandom), 1'b1);
        step(1'b0, 5'b00001, 1'b1);
        chk("first_grant_early", {3'b0, obs_grant}, 8'h00);
        step(1'b0, 5'b00000, 1'b1);
        chk("first_grant", {3'b0, obs_grant}, 8'h01);
        repeat (2) step(1'b0, 5'b00000, 1'b1);

        // Single posted write.
        step(1'b0, 5'b00010, 1'b1);
        step(1'b0, 5'b00000, 1'b1);
        chk("a2p2_c1", {3'b0, obs_grant}, 8'h02);
        step(1'b0, 5'b00000, 1'b1);
        chk("a2p2_c2_empty", {7'b0, obs_empty}, 8'h01);
        chk("a2p2_c2_grant", {3'b0, obs_grant}, 8'h00);

        // Arrival order beats priority.
        step(1'b0, 5'b00100, 1'b1);
        step(1'b0, 5'b00101, 1'b1);
        chk("order_master", {3'b0, obs_grant}, 8'h04);
        step(1'b0, 5'b00001, 1'b1);
        chk("order_a2p1", {3'b0, obs_grant}, 8'h01);
        step(1'b0, 5'b00000, 1'b1);

        // Same-cycle arrivals resolved by fixed priority.
        step(1'b0, 5'b11011, 1'b1);
        step(1'b0, 5'b00000, 1'b1);
        chk("same_c1", {3'b0, obs_grant}, 8'h01);
        step(1'b0, 5'b00000, 1'b1);
        chk("same_c2", {3'b0, obs_grant}, 8'h02);
        step(1'b0, 5'b00000, 1'b1);
        chk("same_c3", {3'b0, obs_grant}, 8'h08);
        step(1'b0, 5'b00000, 1'b1);
        chk("same_c4", {3'b0, obs_grant}, 8'h10);
        step(1'b0, 5'b00000, 1'b1);
        chk("same_empty", {7'b0, obs_empty}, 8'h01);

        // Back-pressure: held requests recorded once each.
        step(1'b0, 5'b00100, 1'b0);
        repeat (4) begin
            step(1'b0, 5'b00101, 1'b0);
            chk("stall_nogrant", {3'b0, obs_grant}, 8'h00);
        end
        chk("stall_entries", mq.size(), 8'd2);
        step(1'b0, 5'b00101, 1'b1);
        chk("stall_master", {3'b0, obs_grant}, 8'h04);
        step(1'b0, 5'b00001, 1'b1);
        chk("stall_a2p1", {3'b0, obs_grant}, 8'h01);
        step(1'b0, 5'b00000, 1'b1);
        chk("stall_empty", {7'b0, obs_empty}, 8'h01);

        // Reset mid-sequence discards recorded requests; held valids come back.
        step(1'b0, 5'b00001, 1'b0);
        step(1'b0, 5'b00111, 1'b0);
        step(1'b1, 5'b00111, 1'b1);
        chk("rst_mid_grant", {3'b0, obs_grant}, 8'h00);
        step(1'b0, 5'b00111, 1'b1);
        chk("post_rst_grant", {3'b0, obs_grant}, 8'h00);
        chk("post_rst_empty", {7'b0, obs_empty}, 8'h01);
        step(1'b0, 5'b00110, 1'b1);
        chk("rerecord_a2p1", {3'b0, obs_grant}, 8'h01);
        repeat (4) step(1'b0, 5'b00000, 1'b1);

        // Random traffic with alternating ready-heavy and stall-heavy phases.
        for (int c = 0; c < 3000; c++) begin
            if ((c % 60) == 0) ready_pct = ((c / 60) % 2 == 0) ? 85 : 15;
            rs = ($urandom_range(0, 249) == 0);
            rq = 5'($urandom) & 5'($urandom);
            rr = ($urandom_range(0, 99) < ready_pct);
            step(rs, rq, rr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
